canny_frame_ctrl: RTL and testbench

CANNY_FRAME_CTRL -- requirements
Module: canny_frame_ctrl

---
 rtl/canny_frame_ctrl.sv | 134 +++++++++++++
 tb/tb_canny_frame_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/canny_frame_ctrl.sv
// Frame controller for the four-stage 3x3 Canny pipeline: feeds IMG_W*IMG_H pixels, then drains (IMG_W-8)*(IMG_H-8) results.
// Latency: one registered cycle from source transfer to pipe_enable, and from pipe_ready to out_valid.
// Backpressure: source is accepted only in FEED; the pipeline output cannot be stalled, and a silent drain ends in a sticky ERR.
module canny_frame_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 512,
  parameter int TMO   = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        src_valid,
  input  logic [15:0] src_data,
  output logic        src_ready,
  output logic        pipe_enable,
  output logic [15:0] pipe_data,
  input  logic        pipe_ready,
  input  logic [15:0] pipe_out,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        err_tmo
);

  localparam int NPIX = IMG_W * IMG_H;
  // Four 3x3 stages each trim a one-pixel border on every side.
  localparam int NOUT = (IMG_W - 8) * (IMG_H - 8);
  localparam int CW   = ($clog2(NPIX + 1) > 24) ? $clog2(NPIX + 1) : 24;
  localparam int TW   = $clog2(TMO + 1);

  localparam logic [CW-1:0] LAST_IN  = CW'(NPIX - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(NOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [TW-1:0] LAST_TMO = TW'(TMO - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          xfer;
  logic          fwd;

  assign src_ready = (state == FEED);
  assign busy      = (state != IDLE);
  assign xfer      = src_valid && src_ready;
  // Results seen in IDLE are stale; in ERR they are swallowed.
  assign fwd       = pipe_ready && ((state == FEED) || (state == DRAIN));

  // Frame sequencer: state, counters and all registered strobes/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_cnt      <= '0;
      out_cnt     <= '0;
      tmo_cnt     <= '0;
      pipe_enable <= 1'b0;
      pipe_data   <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      done        <= 1'b0;
      err_tmo     <= 1'b0;
    end else begin
      pipe_enable <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      done        <= 1'b0;

      if (xfer) begin
        pipe_enable <= 1'b1;
        pipe_data   <= src_data;
        in_cnt      <= in_cnt + CNT_ONE;
      end

      if (fwd) begin
        out_valid <= 1'b1;
        out_data  <= pipe_out;
        out_last  <= (out_cnt == LAST_OUT);
        out_cnt   <= out_cnt + CNT_ONE;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= FEED;
            in_cnt  <= '0;
            out_cnt <= '0;
            tmo_cnt <= '0;
          end
        end
        FEED: begin
          // The full output count before the input is exhausted means a corrupt frame.
          if (fwd && (out_cnt == LAST_OUT)) begin
            state <= ERR;
          end else if (xfer && (in_cnt == LAST_IN)) begin
            state   <= DRAIN;
            tmo_cnt <= '0;
          end
        end
        DRAIN: begin
          if (fwd) begin
            tmo_cnt <= '0;
            if (out_cnt == LAST_OUT) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end else if (tmo_cnt == LAST_TMO) begin
            state   <= ERR;
            err_tmo <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_canny_frame_ctrl.sv
module tb_canny_frame_ctrl;

  localparam int W    = 12;
  localparam int H    = 10;
  localparam int T    = 16;
  localparam int NPIX = W * H;
  localparam int NOUT = (W - 8) * (H - 8);

  typedef logic [15:0] pix_q_t[$];

  logic        clk = 1'b0;
  logic        rst, start, src_valid, pipe_ready;
  logic [15:0] src_data, pipe_out;
  logic        src_ready, pipe_enable, out_valid, out_last, busy, done, err_tmo;
  logic [15:0] pipe_data, out_data;

  always #5 clk = ~clk;

  canny_frame_ctrl #(.IMG_W(W), .IMG_H(H), .TMO(T)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .pipe_enable(pipe_enable), .pipe_data(pipe_data),
    .pipe_ready(pipe_ready), .pipe_out(pipe_out),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .err_tmo(err_tmo)
  );

  int n_checks = 0;
  int n_fail   = 0;

  pix_q_t exp_pipe, got_pipe, exp_out, got_out;
  int done_cnt, done_with_last, last_cnt, last_pos;
  int bad_en, bad_rdy, bad_hold;

  function automatic int q_diff(input pix_q_t a, input pix_q_t b);
    int d;
    int n;
    d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) d++;
    return d;
  endfunction

  task automatic clear_rec();
    exp_pipe.delete(); got_pipe.delete(); exp_out.delete(); got_out.delete();
    done_cnt = 0; done_with_last = 0; last_cnt = 0; last_pos = -1;
    bad_en = 0; bad_rdy = 0; bad_hold = 0;
  endtask

  // Advance one clock and record what the DUT presented after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pipe_enable === 1'b1) got_pipe.push_back(pipe_data);
    if (out_valid === 1'b1) begin
      got_out.push_back(out_data);
      if (out_last === 1'b1) begin
        last_cnt++;
        last_pos = got_out.size();
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (out_last === 1'b1 && out_valid === 1'b1) done_with_last++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Feed n_xfer pixels; the model expects the frame to accept on every valid cycle.
  task automatic feed_frame(input bit toggle, input int n_rdy, input int n_xfer);
    int acc = 0;
    int cyc = 0;
    int rdy_sent = 0;
    bit pv;
    while (acc < n_xfer && cyc < 1000) begin
      if (src_ready !== 1'b1) bad_rdy++;
      pv = toggle ? ~cyc[0] : 1'b1;
      src_valid = pv;
      src_data = 16'($urandom);
      pipe_ready = (rdy_sent < n_rdy) && (cyc % 10 == 5);
      pipe_out = 16'($urandom);
      if (pipe_ready) begin
        exp_out.push_back(pipe_out);
        rdy_sent++;
      end
      if (pv) begin
        exp_pipe.push_back(src_data);
        acc++;
      end
      tick();
      if (pipe_enable !== pv) bad_en++;
      if (!pv && acc > 0 && pipe_data !== exp_pipe[$]) bad_hold++;
      cyc++;
    end
    src_valid = 1'b0;
    pipe_ready = 1'b0;
    n_checks++;
    if (acc != n_xfer) begin
      n_fail++;
      $display("FAIL feed_budget: accepted %0d required %0d", acc, n_xfer);
    end
  endtask

  // n result pulses, each after a short random gap well under the timeout.
  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      pipe_ready = 1'b1;
      pipe_out = 16'($urandom);
      exp_out.push_back(pipe_out);
      tick();
      pipe_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = '0; pipe_ready = 1'b0; pipe_out = '0;
    clear_rec();
    tick(); tick();
    n_checks++;
    if ({busy, src_ready, pipe_enable, out_valid, out_last, done, err_tmo} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: actual %b required 0000000",
               {busy, src_ready, pipe_enable, out_valid, out_last, done, err_tmo});
    end
    n_checks++;
    if ({pipe_data, out_data} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: actual %h/%h required 0/0", pipe_data, out_data);
    end
    rst = 1'b0;
    pipe_ready = 1'b1; pipe_out = 16'habcd;
    tick(); tick(); tick();
    pipe_ready = 1'b0;
    tick();
    n_checks++;
    if (got_out.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignore: outputs %0d busy %b required 0 and 0", got_out.size(), busy);
    end
  endtask

  task automatic run_full_frame(input string name, input bit toggle);
    clear_rec();
    pulse_start();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_busy: actual %b required 1", name, busy);
    end
    feed_frame(toggle, 0, NPIX);
    n_checks++;
    if (bad_rdy != 0 || bad_en != 0 || bad_hold != 0) begin
      n_fail++;
      $display("FAIL %s_feed_timing: ready %0d enable %0d hold %0d bad cycles required 0", name, bad_rdy, bad_en, bad_hold);
    end
    n_checks++;
    if (src_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_drain_state: src_ready %b busy %b required 0 1", name, src_ready, busy);
    end
    drain(NOUT);
    n_checks++;
    if (q_diff(got_pipe, exp_pipe) != 0) begin
      n_fail++;
      $display("FAIL %s_pipe_stream: got %0d pixels (%0d diffs) required %0d", name, got_pipe.size(), q_diff(got_pipe, exp_pipe), NPIX);
    end
    n_checks++;
    if (q_diff(got_out, exp_out) != 0 || last_pos != NOUT) begin
      n_fail++;
      $display("FAIL %s_out_stream: got %0d last at %0d required %0d", name, got_out.size(), last_pos, NOUT);
    end
    n_checks++;
    if (done_cnt != 1 || done_with_last != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: done %0d with_last %0d busy %b required 1 1 0", name, done_cnt, done_with_last, busy);
    end
  endtask

  task automatic test_continuous();
    run_full_frame("continuous", 1'b0);
  endtask

  task automatic test_toggle();
    run_full_frame("toggle", 1'b1);
  endtask

  task automatic test_feed_outputs();
    clear_rec();
    pulse_start();
    feed_frame(1'b0, 3, NPIX);
    n_checks++;
    if (got_out.size() != 3 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL feed_outputs_forwarded: actual %0d done %0d required 3 0", got_out.size(), done_cnt);
    end
    drain(NOUT - 3);
    n_checks++;
    if (q_diff(got_out, exp_out) != 0 || last_pos != NOUT || done_cnt != 1 || done_with_last != 1) begin
      n_fail++;
      $display("FAIL feed_outputs_done: outputs %0d last %0d done %0d required %0d %0d 1",
               got_out.size(), last_pos, done_cnt, NOUT, NOUT);
    end
  endtask

  task automatic test_timeout();
    int n_o;
    int n_p;
    clear_rec();
    pulse_start();
    feed_frame(1'b0, 0, NPIX);
    drain(5);
    repeat (T - 1) tick();
    n_checks++;
    if (err_tmo !== 1'b0 || busy !== 1'b1 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL tmo_early: err_tmo %b busy %b done %0d required 0 1 0", err_tmo, busy, done_cnt);
    end
    tick();
    n_checks++;
    if (err_tmo !== 1'b1 || busy !== 1'b1 || src_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_fire: err_tmo %b busy %b src_ready %b required 1 1 0", err_tmo, busy, src_ready);
    end
    n_o = got_out.size();
    n_p = got_pipe.size();
    start = 1'b1; src_valid = 1'b1; pipe_ready = 1'b1;
    repeat (20) tick();
    start = 1'b0; src_valid = 1'b0; pipe_ready = 1'b0;
    n_checks++;
    if (got_out.size() != n_o || got_pipe.size() != n_p || err_tmo !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: new outs %0d new pipes %0d err %b busy %b required 0 0 1 1",
               got_out.size() - n_o, got_pipe.size() - n_p, err_tmo, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (err_tmo !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_reset: err %b busy %b required 0 0", err_tmo, busy);
    end
  endtask

  task automatic test_mid_reset();
    clear_rec();
    pulse_start();
    feed_frame(1'b0, 3, NPIX / 2);
    rst = 1'b1;
    tick();
    n_checks++;
    if ({busy, src_ready, pipe_enable, out_valid, out_last, done, err_tmo} !== 7'b0 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL midreset_flags: actual %b done %0d required 0000000 0",
               {busy, src_ready, pipe_enable, out_valid, out_last, done, err_tmo}, done_cnt);
    end
    n_checks++;
    if ({pipe_data, out_data} !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_data: actual %h/%h required 0/0", pipe_data, out_data);
    end
    rst = 1'b0;
    tick();
    run_full_frame("after_reset", 1'b0);
  endtask

  task automatic test_back_to_back();
    clear_rec();
    start = 1'b1;
    tick();
    for (int f = 0; f < 2; f++) begin
      feed_frame(1'b0, 0, NPIX);
      drain(NOUT);
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_idle_%0d: done %b busy %b required 1 0", f, done, busy);
      end
      if (f == 1) start = 1'b0;
      tick();
      n_checks++;
      if (busy !== (f == 0) || done !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_relaunch_%0d: busy %b done %b required %0d 0", f, busy, done, f == 0);
      end
    end
    n_checks++;
    if (done_cnt != 2 || last_cnt != 2 || q_diff(got_pipe, exp_pipe) != 0 || q_diff(got_out, exp_out) != 0) begin
      n_fail++;
      $display("FAIL b2b_totals: done %0d last %0d pipe %0d out %0d required 2 2 %0d %0d",
               done_cnt, last_cnt, got_pipe.size(), got_out.size(), 2 * NPIX, 2 * NOUT);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_continuous();
    test_toggle();
    test_feed_outputs();
    test_timeout();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
